// File: rtl/control_store.sv
// control_store: 512 x 36 microcode store with a two-state IDLE/RUN
// controller. In IDLE the store accepts programming writes and MIR is held at
// the NOP word. In RUN the store is read at MPC and MIR follows one cycle
// later.
// Optional feature: define CS_PARITY_EN to keep an even-parity bit per word.
// Every RUN read is then checked, and a mismatch raises the sticky parity_err.
module control_store (
    input  logic        clk,
    input  logic        rst,
    input  logic [8:0]  MPC,
    input  logic        run,
    input  logic        prog_valid,
    input  logic [8:0]  prog_addr,
    input  logic [35:0] prog_data,
    output logic        prog_ready,
    output logic [35:0] MIR,
    output logic        busy,
    output logic [9:0]  prog_count,
    output logic        parity_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

`ifdef CS_PARITY_EN
    localparam int WORD_W = 37;

    // Even parity over a 36-bit microinstruction.
    function automatic logic even_parity(input logic [35:0] d);
        return ^d;
    endfunction
`else
    localparam int WORD_W = 36;
`endif

    localparam logic [9:0] COUNT_MAX = 10'd512;

    logic [WORD_W-1:0] mem_r [0:511];

    state_t            state_r;
    logic [35:0]       mir_r;
    logic              busy_r;
    logic [9:0]        count_r;

    logic              wr_en_s;
    logic              rd_en_s;
    logic [WORD_W-1:0] wr_word_s;
    logic [WORD_W-1:0] rd_word_s;

    // A word offered while reset is low is dropped, even though prog_ready is high then.
    assign prog_ready = (state_r == ST_IDLE);
    assign wr_en_s    = prog_valid & prog_ready & rst;
    assign rd_en_s    = (state_r == ST_RUN) & run;
    assign rd_word_s  = mem_r[MPC];

`ifdef CS_PARITY_EN
    assign wr_word_s  = {even_parity(prog_data), prog_data};
`else
    assign wr_word_s  = prog_data;
`endif

    // Microcode storage: synchronous write, not touched by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[prog_addr] <= wr_word_s;
        end else begin
            mem_r[prog_addr] <= mem_r[prog_addr];
        end
    end

    // Controller, MIR load and saturating write counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            mir_r   <= 36'd0;
            count_r <= 10'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run && !prog_valid) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (run) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase

            // NOP on every edge that is not a RUN->RUN edge, so execution starts at 0.
            if (rd_en_s) begin
                mir_r <= rd_word_s[35:0];
            end else begin
                mir_r <= 36'd0;
            end

            if (wr_en_s && (count_r != COUNT_MAX)) begin
                count_r <= count_r + 10'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

`ifdef CS_PARITY_EN
    logic perr_r;
    logic perr_hit_s;

    assign perr_hit_s = rd_en_s & (even_parity(rd_word_s[35:0]) != rd_word_s[36]);

    // Sticky parity error, raised on the same edge that MIR loads the bad word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perr_r <= 1'b0;
        end else if (perr_hit_s) begin
            perr_r <= 1'b1;
        end else begin
            perr_r <= perr_r;
        end
    end

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

    assign MIR        = mir_r;
    assign busy       = busy_r;
    assign prog_count = count_r;

endmodule
